// File: rtl/gaussian_io_pkg.sv
// ---------------------------------------------------------------------------
// gaussian_io_pkg
// Shared types and constants for the picoMIPS Gaussian-filter input stage.
//   dbnc_state_t : pushbutton debounce FSM state encoding
//   SYNC_STAGES  : depth of every input synchroniser chain
//   cnt_width()  : width of a counter that must hold 0 .. cycles-1
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package gaussian_io_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } dbnc_state_t;

  localparam int SYNC_STAGES = 2;

  // A counter that only ever needs to reach cycles-1 is $clog2(cycles) wide.
  // The result is clamped to one bit so that degenerate values still
  // elaborate to a legal vector.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : gaussian_io_pkg

// File: rtl/sw_key_debounce_strobe_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Multi-bit flop-chain synchroniser for asynchronous board inputs. Every bit
// is resynchronised independently, so it suits only slowly changing inputs
// such as switches and buttons. The reset value is a parameter: the
// pushbutton chain resets to "released" (1), and the switch chain resets
// to 0.
// Ports:
//   clk_i   in   1      sampling clock, rising edge
//   rst_ni  in   1      asynchronous active-low reset
//   d_i     in   WIDTH  asynchronous input
//   q_o     out  WIDTH  synchronised output, SYNC_STAGES cycles later
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_2ff
  import gaussian_io_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule : sync_2ff

// File: rtl/sw_key_debounce_strobe.sv
// ---------------------------------------------------------------------------
// sw_key_debounce_strobe
// Front-end input stage for the picoMIPS Gaussian-filter core. This block
// synchronises the slide switches and the active-low pushbutton, then
// debounces the button. Each accepted press captures the synchronised
// switch byte as the processor's SW operand and raises branch_status.
// branch_status stays high until the release has been stable for the full
// debounce time.
//
// Parameters:
//   DBNC_CYCLES  stable-level cycles needed to accept a press or release
//                (minimum 2)
//   SW_WIDTH     width of the switch bus and of the captured operand
// Ports:
//   fastclk        in   1         system clock, rising edge
//   reset          in   1         asynchronous active-low reset
//   key_n          in   1         raw pushbutton, active-low, bouncy
//   sw_raw         in   SW_WIDTH  raw slide switches
//   SW             out  SW_WIDTH  captured operand (registered)
//   branch_status  out  1         high while an accepted press is held
//   press_cnt      out  8         accepted-press count, wraps 255->0
//                                 (present only when PRESS_COUNT_EN is defined)
// Configuration macro: PRESS_COUNT_EN
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sw_key_debounce_strobe
  import gaussian_io_pkg::*;
#(
  parameter int DBNC_CYCLES = 250000,
  parameter int SW_WIDTH    = 8
) (
  input  logic                fastclk,
  input  logic                reset,
  input  logic                key_n,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [SW_WIDTH-1:0] SW,
  output logic                branch_status
`ifdef PRESS_COUNT_EN
  ,
  output logic [7:0]          press_cnt
`endif
);

  localparam int               CNT_W    = cnt_width(DBNC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

  logic                key_s;
  logic [SW_WIDTH-1:0] sw_s;

  dbnc_state_t         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [SW_WIDTH-1:0] sw_q,    sw_d;
  logic                strobe_q, strobe_d;

  // The button chain resets to 1 so that reset itself never looks like a press.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_key_sync (
    .clk_i  (fastclk),
    .rst_ni (reset),
    .d_i    (key_n),
    .q_o    (key_s)
  );

  sync_2ff #(
    .WIDTH     (SW_WIDTH),
    .RESET_VAL ('0)
  ) u_sw_sync (
    .clk_i  (fastclk),
    .rst_ni (reset),
    .d_i    (sw_raw),
    .q_o    (sw_s)
  );

  // Debounce FSM. The counter is cleared on every state entry, so the count
  // measures how long the level has been stable in the current wait state.
  // Any contrary sample during a wait state abandons that wait as bounce.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sw_d     = sw_q;
    strobe_d = strobe_q;

    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HELD;
          cnt_d    = '0;
          sw_d     = sw_s;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HELD: begin
        if (key_s) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end

      REL_WAIT: begin
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          strobe_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        strobe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sw_q     <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_q     <= sw_d;
      strobe_q <= strobe_d;
    end
  end

  assign SW            = sw_q;
  assign branch_status = strobe_q;

`ifdef PRESS_COUNT_EN
  logic       accept_press;
  logic [7:0] press_cnt_q;

  // A press is accepted only when leaving PRESS_WAIT for HELD. IDLE has no
  // direct path to HELD.
  assign accept_press = (state_q == PRESS_WAIT) && !key_s && (cnt_q == CNT_LAST);

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      press_cnt_q <= 8'd0;
    end else if (accept_press) begin
      press_cnt_q <= press_cnt_q + 8'd1;
    end
  end

  assign press_cnt = press_cnt_q;
`endif

`ifndef SYNTHESIS
  // The counter stops at its terminal value and never wraps.
  a_cnt_bound : assert property (@(posedge fastclk) disable iff (!reset)
    cnt_q <= CNT_LAST);

  // branch_status is high exactly while the button is considered held.
  a_strobe_state : assert property (@(posedge fastclk) disable iff (!reset)
    strobe_q == ((state_q == HELD) || (state_q == REL_WAIT)));
`endif

endmodule : sw_key_debounce_strobe

// File: tb/tb_sw_key_debounce_strobe.sv
`timescale 1ns/1ps

module tb_sw_key_debounce_strobe;

  localparam int DBNC = 4;
  localparam int SWW  = 8;

  logic           fastclk;
  logic           reset;
  logic           key_n;
  logic [SWW-1:0] sw_raw;
  logic [SWW-1:0] SW;
  logic           branch_status;
`ifdef PRESS_COUNT_EN
  logic [7:0]     press_cnt;
`endif

  int checks;
  int fails;

  sw_key_debounce_strobe #(
    .DBNC_CYCLES (DBNC),
    .SW_WIDTH    (SWW)
  ) dut (
    .fastclk       (fastclk),
    .reset         (reset),
    .key_n         (key_n),
    .sw_raw        (sw_raw),
    .SW            (SW),
    .branch_status (branch_status)
`ifdef PRESS_COUNT_EN
    ,
    .press_cnt     (press_cnt)
`endif
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  // Reference model. The FSM sees the inputs from two edges earlier. The
  // "held" view toggles once the delayed button level has disagreed with it
  // for DBNC+1 consecutive edges: one edge to leave the settled state and
  // DBNC counted edges to accept the change. A press captures the delayed
  // switch value.
  logic           mKh0, mKh1;
  logic [SWW-1:0] mSh0, mSh1;
  logic           mHeld;
  int             mRun;
  logic [SWW-1:0] mSW;
  logic [7:0]     mCnt;

  always @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      mKh0  <= 1'b1;
      mKh1  <= 1'b1;
      mSh0  <= '0;
      mSh1  <= '0;
      mHeld <= 1'b0;
      mRun  <= 0;
      mSW   <= '0;
      mCnt  <= 8'd0;
    end else begin
      mKh0 <= key_n;
      mKh1 <= mKh0;
      mSh0 <= sw_raw;
      mSh1 <= mSh0;
      if (mHeld ? mKh1 : !mKh1) begin
        if (mRun == DBNC) begin
          mHeld <= !mHeld;
          mRun  <= 0;
          if (!mHeld) begin
            mSW  <= mSh1;
            mCnt <= mCnt + 8'd1;
          end
        end else begin
          mRun <= mRun + 1;
        end
      end else begin
        mRun <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge fastclk);
    @(negedge fastclk);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    key_n  = 1'b1;
    sw_raw = 8'h00;
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (SW !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_sw: got %0h expected 00", SW);
    end
    checks++;
    if (branch_status !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_bs: got %0b expected 0", branch_status);
    end
`ifdef PRESS_COUNT_EN
    checks++;
    if (press_cnt !== 8'd0) begin
      fails++;
      $display("[TB] FAIL reset_cnt: got %0d expected 0", press_cnt);
    end
`endif
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_clean_press();
    sw_raw = 8'h58;
    key_n  = 1'b0;
    repeat (6) tick();
    checks++;
    if (branch_status !== 1'b0) begin
      fails++;
      $display("[TB] FAIL press_edge6_bs: got %0b expected 0", branch_status);
    end
    tick();
    checks++;
    if (branch_status !== 1'b1) begin
      fails++;
      $display("[TB] FAIL press_edge7_bs: got %0b expected 1", branch_status);
    end
    checks++;
    if (SW !== 8'h58) begin
      fails++;
      $display("[TB] FAIL press_edge7_sw: got %0h expected 58", SW);
    end
    key_n = 1'b1;
    repeat (10) tick();
    checks++;
    if (branch_status !== 1'b0) begin
      fails++;
      $display("[TB] FAIL press_released_bs: got %0b expected 0", branch_status);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] swBefore;
`ifdef PRESS_COUNT_EN
    logic [7:0] cntBefore;
    cntBefore = press_cnt;
`endif
    swBefore = SW;
    sw_raw   = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      key_n = (i < 3) ? 1'b0 : (i < 4) ? 1'b1 : (i < 7) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (branch_status !== 1'b0 || branch_status !== mHeld) begin
        fails++;
        $display("[TB] FAIL bounce_bs[%0d]: got %0b expected 0", i, branch_status);
      end
      checks++;
      if (SW !== swBefore) begin
        fails++;
        $display("[TB] FAIL bounce_sw[%0d]: got %0h expected %0h", i, SW, swBefore);
      end
    end
`ifdef PRESS_COUNT_EN
    checks++;
    if (press_cnt !== cntBefore) begin
      fails++;
      $display("[TB] FAIL bounce_cnt: got %0d expected %0d", press_cnt, cntBefore);
    end
`endif
  endtask

  task automatic test_operand_update();
    sw_raw = 8'h58;
    key_n  = 1'b0;
    repeat (7) tick();
    checks++;
    if (branch_status !== 1'b1 || SW !== 8'h58) begin
      fails++;
      $display("[TB] FAIL op_press1: got bs=%0b sw=%0h expected bs=1 sw=58", branch_status, SW);
    end
    sw_raw = 8'h80;
    repeat (5) tick();
    checks++;
    if (SW !== 8'h58) begin
      fails++;
      $display("[TB] FAIL op_held_sw: got %0h expected 58", SW);
    end
    key_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (branch_status !== 1'b1) begin
      fails++;
      $display("[TB] FAIL op_rel_edge6_bs: got %0b expected 1", branch_status);
    end
    tick();
    checks++;
    if (branch_status !== 1'b0) begin
      fails++;
      $display("[TB] FAIL op_rel_edge7_bs: got %0b expected 0", branch_status);
    end
    checks++;
    if (SW !== 8'h58) begin
      fails++;
      $display("[TB] FAIL op_rel_sw_hold: got %0h expected 58", SW);
    end
    repeat (2) tick();
    key_n = 1'b0;
    repeat (7) tick();
    checks++;
    if (branch_status !== 1'b1 || SW !== 8'h80) begin
      fails++;
      $display("[TB] FAIL op_press2: got bs=%0b sw=%0h expected bs=1 sw=80", branch_status, SW);
    end
  endtask

  task automatic test_reset_mid_hold();
    sw_raw = 8'h3C;
    repeat (2) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (branch_status !== 1'b0 || SW !== 8'h00) begin
      fails++;
      $display("[TB] FAIL midreset_async: got bs=%0b sw=%0h expected bs=0 sw=00", branch_status, SW);
    end
    repeat (2) tick();
    reset = 1'b1;
    repeat (6) tick();
    checks++;
    if (branch_status !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_edge6_bs: got %0b expected 0", branch_status);
    end
    tick();
    checks++;
    if (branch_status !== 1'b1 || SW !== 8'h3C) begin
      fails++;
      $display("[TB] FAIL midreset_edge7: got bs=%0b sw=%0h expected bs=1 sw=3c", branch_status, SW);
    end
    key_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      key_n  = 1'($urandom_range(0, 1));
      sw_raw = 8'($urandom);
      len    = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        tick();
        checks++;
        if (branch_status !== mHeld || SW !== mSW) begin
          fails++;
          $display("[TB] FAIL random[%0d.%0d]: got bs=%0b sw=%0h expected bs=%0b sw=%0h",
                   seg, c, branch_status, SW, mHeld, mSW);
        end
`ifdef PRESS_COUNT_EN
        checks++;
        if (press_cnt !== mCnt) begin
          fails++;
          $display("[TB] FAIL random_cnt[%0d.%0d]: got %0d expected %0d", seg, c, press_cnt, mCnt);
        end
`endif
      end
    end
    key_n = 1'b1;
    repeat (12) tick();
  endtask

`ifdef PRESS_COUNT_EN
  task automatic test_press_count();
    reset = 1'b0;
    #1;
    repeat (2) tick();
    reset = 1'b1;
    key_n = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] expCnt;
      expCnt = 8'(i + 1);
      key_n  = 1'b0;
      repeat (8) tick();
      checks++;
      if (press_cnt !== expCnt) begin
        fails++;
        $display("[TB] FAIL press_cnt[%0d]: got %0d expected %0d", i, press_cnt, expCnt);
      end
      key_n = 1'b1;
      repeat (8) tick();
    end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_operand_update();
    test_reset_mid_hold();
    test_random();
`ifdef PRESS_COUNT_EN
    test_press_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_sw_key_debounce_strobe
